// File: rtl/seg_cpa.sv
// Two-stage segmented carry-select adder with runtime lane fusion.
// Stage 1 captures dual-carry segment sums; stage 2 resolves carries per group.
module seg_cpa #(
  parameter int LANES = 4,
  parameter int LW    = 32,
  parameter int SEG   = 16,
  localparam int W    = LANES * LW,
  localparam int NSEG = W / SEG
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [LANES-1:0] sub,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     sum,
  output logic [LANES-1:0] cout,
  output logic [LANES-1:0] ovf
);

  localparam int SPL = LW / SEG;

  logic [LANES-1:0]          lsub_s, ltop_s, msbx_s;
  logic [NSEG-1:0][SEG-1:0]  sum0_s, sum1_s;
  logic [NSEG-1:0]           g_s, p_s, sbase_s, inj_s;

  logic                      s1_valid_r;
  logic [NSEG-1:0][SEG-1:0]  sum0_r, sum1_r;
  logic [NSEG-1:0]           g_r, p_r, sbase_r, inj_r;
  logic [LANES-1:0]          ltop_r, msbx_r;

  logic [W-1:0]              nsum_s;
  logic [NSEG-1:0]           nseg_co_s;
  logic [LANES-1:0]          ncout_s, novf_s;
  logic                      adv_s;

  assign adv_s    = !out_valid || out_ready;
  assign in_ready = !s1_valid_r || adv_s;

  // Decode group framing from mode and build both carry-in variants of every segment.
  always_comb begin
    int gsz;
    int base;
    int l;
    logic [SEG-1:0] bx;
    gsz     = 1;
    base    = 0;
    l       = 0;
    bx      = '0;
    lsub_s  = '0;
    ltop_s  = '0;
    msbx_s  = '0;
    sum0_s  = '0;
    sum1_s  = '0;
    g_s     = '0;
    p_s     = '0;
    sbase_s = '0;
    inj_s   = '0;
    case (mode)
      2'd1:    gsz = 2;
      2'd2:    gsz = LANES;
      default: gsz = 1;
    endcase
    for (int i = 0; i < LANES; i++) begin
      base      = (i / gsz) * gsz;
      lsub_s[i] = sub[base];
      ltop_s[i] = ((i % gsz) == (gsz - 1));
      // Operand MSB parity lets stage 2 recover the carry into the MSB from the sum bit.
      msbx_s[i] = a[i*LW+LW-1] ^ b[i*LW+LW-1] ^ sub[base];
    end
    for (int s = 0; s < NSEG; s++) begin
      l                     = s / SPL;
      bx                    = b[s*SEG +: SEG] ^ {SEG{lsub_s[l]}};
      {g_s[s], sum0_s[s]}   = {1'b0, a[s*SEG +: SEG]} + {1'b0, bx};
      sum1_s[s]             = sum0_s[s] + {{(SEG-1){1'b0}}, 1'b1};
      p_s[s]                = &sum0_s[s];
      sbase_s[s]            = ((s % SPL) == 0) && ((l % gsz) == 0);
      inj_s[s]              = lsub_s[l];
    end
  end

  // Stage 1 register: segment sums, generate/propagate and group framing of the accepted beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      sum0_r     <= '0;
      sum1_r     <= '0;
      g_r        <= '0;
      p_r        <= '0;
      sbase_r    <= '0;
      inj_r      <= '0;
      ltop_r     <= '0;
      msbx_r     <= '0;
    end else if (flush) begin
      s1_valid_r <= 1'b0;
    end else if (in_ready) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        sum0_r  <= sum0_s;
        sum1_r  <= sum1_s;
        g_r     <= g_s;
        p_r     <= p_s;
        sbase_r <= sbase_s;
        inj_r   <= inj_s;
        ltop_r  <= ltop_s;
        msbx_r  <= msbx_s;
      end
    end
  end

  // Ripple segment carries upward, restarting at each group base, and select the matching sums.
  always_comb begin
    logic c;
    logic cin_msb;
    int ts;
    c         = 1'b0;
    cin_msb   = 1'b0;
    ts        = 0;
    nsum_s    = '0;
    nseg_co_s = '0;
    ncout_s   = '0;
    novf_s    = '0;
    for (int s = 0; s < NSEG; s++) begin
      c                       = sbase_r[s] ? inj_r[s] : c;
      nsum_s[s*SEG +: SEG]    = c ? sum1_r[s] : sum0_r[s];
      c                       = g_r[s] | (p_r[s] & c);
      nseg_co_s[s]            = c;
    end
    for (int l = 0; l < LANES; l++) begin
      ts      = (l + 1) * SPL - 1;
      cin_msb = nsum_s[l*LW+LW-1] ^ msbx_r[l];
      if (ltop_r[l]) begin
        ncout_s[l] = nseg_co_s[ts];
        novf_s[l]  = cin_msb ^ nseg_co_s[ts];
      end else begin
        ncout_s[l] = 1'b0;
        novf_s[l]  = 1'b0;
      end
    end
  end

  // Output register: advances when empty or drained, otherwise holds the presented result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= '0;
      ovf       <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (adv_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        sum  <= nsum_s;
        cout <= ncout_s;
        ovf  <= novf_s;
      end
    end
  end

endmodule
